// File: rtl/sseg_display_n.sv
// N-digit seven-segment renderer with frame-synchronised double-buffered patterns and per-digit blink.
// The colour output is registered and appears two cycles after the pixel coordinates are presented.
module sseg_display_n #(
  parameter int          X            = 20,
  parameter int          Y            = 100,
  parameter int          W            = 100,
  parameter int          H            = 200,
  parameter int          N            = 4,
  parameter int          GAP          = 48,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [8:0]  COLOR        = 9'b000_111_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8*N-1:0]   seg,
  input  logic [N-1:0]     blink_en,
  input  logic             load,
  input  logic             frame_start,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             video_on,
  output logic             pending,
  output logic [2:0]       r,
  output logic [2:0]       g,
  output logic [2:0]       b
);

  localparam int VLD   = W / 4;
  localparam int HLD   = H / 7;
  localparam int MID   = H / 2;
  localparam int HVLD  = VLD / 2;
  localparam int HHLD  = HLD / 2;
  localparam int PITCH = W + GAP;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [N-1:0][7:0] shadow_seg, active_seg;
  logic [N-1:0]      shadow_blink, active_blink;
  logic [FW-1:0]     fcnt;
  logic              phase;

  // A load coinciding with frame_start bypasses the shadow and takes effect this frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_seg   <= '0;
      active_seg   <= '0;
      shadow_blink <= '0;
      active_blink <= '0;
      pending      <= 1'b0;
      fcnt         <= '0;
      phase        <= 1'b0;
    end else begin
      if (load && frame_start) begin
        shadow_seg   <= seg;
        active_seg   <= seg;
        shadow_blink <= blink_en;
        active_blink <= blink_en;
        pending      <= 1'b0;
      end else if (load) begin
        shadow_seg   <= seg;
        shadow_blink <= blink_en;
        pending      <= 1'b1;
      end else if (frame_start && pending) begin
        active_seg   <= shadow_seg;
        active_blink <= shadow_blink;
        pending      <= 1'b0;
      end
      if (frame_start) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  int            xi, yi;
  logic          slot_n;
  logic [IW-1:0] idx_n;
  logic [9:0]    dx_n, dy_n;

  always_comb begin
    xi     = int'(x);
    yi     = int'(y);
    slot_n = 1'b0;
    idx_n  = '0;
    dx_n   = '0;
    dy_n   = 10'(yi - Y);
    for (int k = 0; k < N; k++) begin
      if (xi >= X + k * PITCH && xi < X + (k + 1) * PITCH) begin
        slot_n = 1'b1;
        idx_n  = IW'(k);
        dx_n   = 10'(xi - X - k * PITCH);
      end
    end
    if (yi < Y || yi > Y + H) slot_n = 1'b0;
  end

  logic          s1_vld, s1_vid;
  logic [IW-1:0] s1_idx;
  logic [9:0]    s1_dx, s1_dy;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_vid <= 1'b0;
      s1_idx <= '0;
      s1_dx  <= '0;
      s1_dy  <= '0;
    end else begin
      s1_vld <= slot_n;
      s1_vid <= video_on;
      s1_idx <= idx_n;
      s1_dx  <= dx_n;
      s1_dy  <= dy_n;
    end
  end

  int         dxi, dyi;
  logic [7:0] box, pat;
  logic       blank, lit;

  // Box bits follow the pattern byte order {DP,G,F,E,D,C,B,A}.
  always_comb begin
    dxi    = int'(s1_dx);
    dyi    = int'(s1_dy);
    box    = '0;
    box[0] = (dxi <= W) && (dyi <= HLD);
    box[1] = (dxi >= W - VLD) && (dxi <= W) && (dyi <= MID + HVLD);
    box[2] = (dxi >= W - VLD) && (dxi <= W) && (dyi >= MID - HVLD) && (dyi <= H);
    box[3] = (dxi <= W) && (dyi >= H - HLD) && (dyi <= H);
    box[4] = (dxi <= VLD) && (dyi >= MID - HVLD) && (dyi <= H);
    box[5] = (dxi <= VLD) && (dyi <= MID + HVLD);
    box[6] = (dxi <= W) && (dyi >= MID - HVLD) && (dyi <= MID + HVLD);
    box[7] = (dxi >= W + HHLD) && (dxi <= W + HHLD + HLD) && (dyi >= H - VLD) && (dyi <= H);
    pat    = active_seg[s1_idx];
    blank  = phase & active_blink[s1_idx];
    lit    = s1_vld & s1_vid & ~blank & (|(pat & box));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r, g, b} <= '0;
    end else begin
      {r, g, b} <= lit ? COLOR : 9'd0;
    end
  end

endmodule

// File: doc/sseg_display_n.md
# sseg_display_n

Multi-digit, frame-synchronised seven-segment renderer for the VGA path of the kitchen timer. It draws N equal seven-segment glyphs side by side from one shared geometry. Segment patterns are double-buffered and swapped only at frame start, so the display never tears. Per-digit blinking is driven by a frame counter, and the pixel colour is produced through a 2-stage registered pipeline that feeds the VGA output mux.

## Interface
- X, 20: left edge of digit 0 (pixels)
- Y, 100: top edge of all digits
- W, 100: digit body width
- H, 200: digit height
- N, 4: digit count (1..8)
- GAP, 48: horizontal space between digit bodies; must exceed W/4... constraint: GAP > (H/7)/2 + H/7
- BLINK_FRAMES, 30: frames per blink half-period (>=1)
- COLOR, 9'b000_111_000: lit colour {r,g,b}

- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- seg  in  8*N  patterns; byte k = digit k (k=0 leftmost), bits {DP,G,F,E,D,C,B,A}, MSB=DP
- blink_en  in  N  per-digit blink enable
- load  in  1  capture seg/blink_en into shadow set
- frame_start  in  1  one-cycle pulse at start of frame
- x, y  in  10 each  current pixel coordinates
- video_on  in  1  active-video qualifier
- pending  out  1  shadow set loaded but not yet active
- r, g, b  out  3 each  pixel colour (registered)

## Operation
- Geometry: VLD=W/4, HLD=H/7, MID=H/2, hVLD=VLD/2, hHLD=HLD/2 (integer division). Digit k origin Xk = X + k*(W+GAP). All bounds are inclusive. dx = x-Xk, dy = y-Y.
- Segment boxes (dx range; dy range):
  - A: 0..W; 0..HLD
  - D: 0..W; H-HLD..H
  - G: 0..W; MID-hVLD..MID+hVLD
  - F: 0..VLD; 0..MID+hVLD
  - E: 0..VLD; MID-hVLD..H
  - B: W-VLD..W; 0..MID+hVLD
  - C: W-VLD..W; MID-hVLD..H
  - DP: W+hHLD..W+hHLD+HLD; H-VLD..H
- Digit select: pixel belongs to digit k if Xk <= x < Xk+W+GAP and 0 <= k < N. Pixels outside every slot, or with y outside Y..Y+H, are background.
- Pixel output: lit (COLOR) if the bit of active digit k is set, the pixel is inside that segment box, video_on=1, and the digit is not blanked. Otherwise 0.
- Double buffer:
  - load=1 copies seg/blink_en to shadow and sets pending=1.
  - frame_start with pending=1 copies shadow to active and clears pending.
  - load and frame_start in the same cycle: the input values go directly to both shadow and active, and pending=0.
  - load while pending=1 overwrites shadow.
- Blink:
  - fcnt counts frame_start pulses 0..BLINK_FRAMES-1. On wrap it returns to 0 and toggles phase.
  - Digit k is blanked when phase=1 and active blink_en[k]=1.
  - Non-blinking digits are unaffected.
- Reset values: active, shadow, fcnt, phase=0 (visible), pending=0, all pipeline registers 0, r=g=b=0.

## Timing
- Pixel latency is 2 cycles. x/y/video_on presented in cycle t are registered at the end of t (stage 1: digit index, dx, dy). Colour is registered at the end of t+1 (stage 2: hit test) and appears on r/g/b during t+2.
- Stage 2 reads the active set and phase. frame_start in cycle t updates them at the end of t, so the pixel presented in cycle t is the first rendered with the new data.
- pending rises the cycle after load and falls the cycle after the consuming frame_start.
- rst asserted mid-frame clears everything at the next edge. r/g/b read 0 from the following cycle until 2 cycles after the first post-reset pixel. Any load in the reset cycle is ignored.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst 3 cycles with x=30, y=105, video_on=1 -> r=g=b=0 and pending=0. Without a load, all pixels stay black.
- Basic render:
  - Stimulus: seg byte0=8'h3F, load + frame_start together; then x=30, y=105.
  - Expected: g=3'b111, r=b=0 two cycles later. x=70, y=200 (G region) -> black. x=20, y=100 -> lit. x=19, y=100 -> black.
- Frame sync: load byte0=8'h06 without frame_start.
  - Expected: pending=1, and x=30, y=105 stays lit (old "0").
  - Then pulse frame_start -> pending=0 next cycle, and the same pixel is black.
- DP and second digit: byte1=8'h80 active.
  - Expected: x=282, y=275 lit. x=281, y=275 black. x=310, y=300 lit. x=311, y=300 black.
- Blink: BLINK_FRAMES=2, bytes 0/1=8'hFF, blink_en=2'b01.
  - Expected: after 2 frame_starts, digit 0 is black and digit 1 is still lit. After 4 frame_starts, digit 0 is lit again.
- Qualifiers: video_on=0 on a lit pixel -> black. rst mid-frame -> outputs 0, pending=0, and the active set is cleared.
